// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the buffered UART transmitter
//            and the upstream capture sequencer.
// Options  : UART_TX_PARITY_EN adds a PARITY state (even parity).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    // Frame sync bytes emitted by the sequencer ahead of each sample group
    localparam logic [7:0] UART_SYNC0 = 8'hAA;
    localparam logic [7:0] UART_SYNC1 = 8'hBB;
    localparam logic [7:0] UART_SYNC2 = 8'hCC;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/uart_byte_fifo.sv
// ============================================================================
// Module   : uart_byte_fifo
// Brief    : Byte FIFO with show-ahead read data. Depth must be a power of
//            two so the pointers wrap naturally. The caller never writes
//            when full without a simultaneous read, nor reads when empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_p,
    input  logic                     write_i,
    input  logic                     read_i,
    input  logic [7:0]               write_data_i,
    output logic [7:0]               read_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    // Next pointer and occupancy values; a simultaneous write and read leaves the count unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (write_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (read_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({write_i, read_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (write_i) begin
            mem_q[wr_ptr_q] <= write_data_i;
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign read_data_o = mem_q[rd_ptr_q];
    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == (AW+1)'(DEPTH));
    assign count_o     = count_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx_buf.sv
// ============================================================================
// Module   : uart_tx_buf
// Brief    : Buffered 8N1 UART transmitter. Bytes written into a small FIFO
//            are serialised LSB-first; empty/full/done/overflow are exported
//            for the upstream sequencer to poll.
// Options  : UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       uart_tx_data_we,
    input  logic [7:0] uart_tx_data,
    output logic       uart_empty,
    output logic       uart_full,
    output logic       uart_done,
    output logic       overflow,
    output logic       tx
);

    localparam int                TW       = $clog2(CLK_DIV);
    localparam int                CW       = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0]     TMR_LOAD = TW'(CLK_DIV - 1);
    localparam logic [2:0]        LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [TW-1:0]  tmr_q,   tmr_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic           tx_q,    tx_d;
    logic           ovf_q,   ovf_d;
`ifdef UART_TX_PARITY_EN
    logic           par_q,   par_d;
`endif

    logic           w_pop;
    logic           w_accept;
    logic           w_tmr_done;
    logic [7:0]     w_head;
    logic           w_fifo_empty;
    logic           w_fifo_full;
    logic [CW:0]    w_count;

    // A full FIFO still takes a byte when the serialiser pops in the same cycle
    assign w_accept   = uart_tx_data_we & (~w_fifo_full | w_pop);
    assign ovf_d      = ovf_q | (uart_tx_data_we & ~w_accept);
    assign w_tmr_done = (tmr_q == '0);

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset_p      (reset_p),
        .write_i      (w_accept),
        .read_i       (w_pop),
        .write_data_i (uart_tx_data),
        .read_data_o  (w_head),
        .empty_o      (w_fifo_empty),
        .full_o       (w_fifo_full),
        .count_o      (w_count)
    );

    // Serialiser next state: every bit period runs the timer from CLK_DIV-1 down to 0
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        tmr_d     = tmr_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        w_pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!w_fifo_empty) begin
                    w_pop   = 1'b1;
                    shift_d = w_head;
                    tmr_d   = TMR_LOAD;
                    tx_d    = 1'b0;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^w_head;
`endif
                end
            end
            START: begin
                if (w_tmr_done) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    tmr_d     = TMR_LOAD;
                    state_d   = DATA;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            DATA: begin
                if (w_tmr_done) begin
                    tmr_d = TMR_LOAD;
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_tmr_done) begin
                    tx_d    = 1'b1;
                    tmr_d   = TMR_LOAD;
                    state_d = STOP;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
`endif
            STOP: begin
                if (w_tmr_done) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Serialiser registers; reset abandons any frame and forces the line high at once
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            tmr_q     <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            tmr_q     <= tmr_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign uart_empty = (w_count == '0);
    assign uart_full  = (w_count == (CW+1)'(FIFO_DEPTH));
    assign uart_done  = uart_empty & (state_q == IDLE);
    assign overflow   = ovf_q;
    assign tx         = tx_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buf.sv
// ============================================================================
// Module   : tb_uart_tx_buf
// Brief    : Self-checking bench for uart_tx_buf (CLK_DIV=4, FIFO_DEPTH=4).
//            A line monitor decodes frames from tx; a transaction-level
//            model predicts accepted bytes, status levels and frame timing.
// Options  : UART_TX_PARITY_EN must match the RTL build.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_buf;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FR     = NBITS * DIV;   // frame length in cycles
    localparam int PERIOD = FR + 1;        // back-to-back frame period
    localparam int TBIT   = DIV * 10;      // one bit in time units

    logic       clk = 1'b0;
    logic       reset_p;
    logic       we;
    logic [7:0] din;
    logic       empty, full, done, ovf, tx;

    int n_tests = 0;
    int n_fail  = 0;
    int ecnt    = 0;

    uart_tx_buf #(
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset_p         (reset_p),
        .uart_tx_data_we (we),
        .uart_tx_data    (din),
        .uart_empty      (empty),
        .uart_full       (full),
        .uart_done       (done),
        .overflow        (ovf),
        .tx              (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt++;

    // ---------------- line monitor ----------------
    logic [7:0] rx_b[$];
    int         rx_e[$];
    bit         rx_ok[$];
    bit         rx_p[$];
    bit         mon_abort = 1'b0;

    always @(posedge reset_p) mon_abort = 1'b1;

    always begin : mon
        logic [7:0] b;
        logic       ok;
        logic       p;
        int         fe;
        @(negedge tx);
        if (reset_p === 1'b0) begin
            mon_abort = 1'b0;
            fe = ecnt;
            p  = 1'b0;
            #(TBIT/2);
            ok = (tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
                #(TBIT);
                b[i] = tx;
            end
`ifdef UART_TX_PARITY_EN
            #(TBIT);
            p = tx;
`endif
            #(TBIT);
            ok = ok && (tx === 1'b1);
            if (!mon_abort) begin
                rx_b.push_back(b);
                rx_e.push_back(fe);
                rx_ok.push_back(ok);
                rx_p.push_back(p);
            end
        end
    end

    // ---------------- transaction-level model ----------------
    logic [7:0] m_fifo[$];
    logic [7:0] m_exp[$];
    int         m_busy_end;   // edge after which the line is idle again
    bit         m_ovf;

    task automatic model_reset();
        m_fifo.delete();
        m_exp.delete();
        m_busy_end = -1;
        m_ovf      = 1'b0;
        rx_b.delete();
        rx_e.delete();
        rx_ok.delete();
        rx_p.delete();
    endtask

    task automatic model_edge(input logic w, input logic [7:0] d, input int e);
        bit pop;
        pop = (m_fifo.size() > 0) && (e > m_busy_end);
        if (pop) begin
            m_exp.push_back(m_fifo.pop_front());
            m_busy_end = e + FR;
        end
        if (w) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
            else                       m_ovf = 1'b1;
        end
    endtask

    function automatic logic m_done();
        return (m_fifo.size() == 0) && (ecnt >= m_busy_end);
    endfunction

    function automatic logic fbit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic int qe(input int i);
        return (i < rx_e.size()) ? rx_e[i] : -1;
    endfunction

    function automatic logic [7:0] qb(input int i);
        return (i < rx_b.size()) ? rx_b[i] : 8'hxx;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic w, input logic [7:0] d);
        we  = w;
        din = d;
        @(posedge clk);
        #1;
        model_edge(w, d, ecnt);
        we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_p = 1'b1;
        @(posedge clk);
        #1;
        reset_p = 1'b0;
        model_reset();
    endtask

    task automatic run_until_done(input int bound, output int e_done);
        int n;
        n = 0;
        while (done !== 1'b1 && n < bound) begin
            tick(1'b0, 8'h00);
            n++;
        end
        check("done_within_bound", done, 1'b1);
        e_done = ecnt;
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_frame_count"}, rx_b.size(), m_exp.size());
        for (int i = 0; i < rx_b.size() && i < m_exp.size(); i++) begin
            check({tag, "_byte"}, rx_b[i], m_exp[i]);
            check({tag, "_framing"}, rx_ok[i], 1'b1);
`ifdef UART_TX_PARITY_EN
            check({tag, "_parity"}, rx_p[i], ^m_exp[i]);
`endif
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin : main
        int         n0, ed, nlow;
        logic [63:0] pat, expv;
        logic [7:0]  bb [6];
        logic        w;

        reset_p = 1'b1;
        we      = 1'b0;
        din     = 8'h00;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_done", done, 1'b1);
        check("rst_overflow", ovf, 1'b0);
        @(posedge clk);
        #1;
        reset_p = 1'b0;

        // single byte: exact line waveform and done timing
        tick(1'b1, 8'hA5);
        n0 = ecnt;
        check("t1_empty_after_write", empty, 1'b0);
        check("t1_tx_idle_at_write", tx, 1'b1);
        pat  = '0;
        expv = '0;
        for (int k = 1; k <= FR + 1; k++) begin
            tick(1'b0, 8'h00);
            pat[k]  = tx;
            expv[k] = (k <= FR) ? fbit(8'hA5, (k - 1) / DIV) : 1'b1;
            if (k == FR)     check("t1_done_low_in_stop", done, 1'b0);
            if (k == FR + 1) check("t1_done_after_frame", done, 1'b1);
        end
        check("t1_line_pattern", pat, expv);
        check_stream("t1");

        // sync bytes back to back
        do_reset();
        tick(1'b1, 8'hAA);
        n0 = ecnt;
        tick(1'b1, 8'hBB);
        tick(1'b1, 8'hCC);
        run_until_done(6 * PERIOD, ed);
        check("t2_done_time", ed - n0, 3 * PERIOD);
        check("t2_fall0", qe(0) - n0, 1);
        check("t2_fall1", qe(1) - n0, 1 + PERIOD);
        check("t2_fall2", qe(2) - n0, 1 + 2 * PERIOD);
        check("t2_b0", qb(0), 8'hAA);
        check("t2_b1", qb(1), 8'hBB);
        check("t2_b2", qb(2), 8'hCC);
        check_stream("t2");

        // burst of six into a depth-4 FIFO
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bb[i] = 8'($urandom);
            tick(1'b1, bb[i]);
            if (i == 4) begin
                check("t3_full_after_5", full, 1'b1);
                check("t3_no_ovf_after_5", ovf, 1'b0);
            end
        end
        check("t3_full_after_6", full, 1'b1);
        check("t3_ovf_after_6", ovf, 1'b1);
        run_until_done(8 * PERIOD, ed);
        check("t3_frames", rx_b.size(), 5);
        for (int i = 0; i < 5; i++) check("t3_byte", qb(i), bb[i]);
        check("t3_ovf_sticky", ovf, 1'b1);
        check_stream("t3");

        // write while full in the same cycle as a pop
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bb[i] = 8'($urandom);
            tick(1'b1, bb[i]);
            if (i == 0) n0 = ecnt;
        end
        check("t4_full_before", full, 1'b1);
        while (ecnt < n0 + FR + 1) tick(1'b0, 8'h00);
        tick(1'b1, 8'h3C);
        check("t4_full_kept", full, 1'b1);
        check("t4_no_ovf", ovf, 1'b0);
        run_until_done(8 * PERIOD, ed);
        check("t4_second_fall", qe(1) - n0, 1 + PERIOD);
        check("t4_frames", rx_b.size(), 6);
        check("t4_last_byte", qb(5), 8'h3C);
        check("t4_ovf_model", ovf, m_ovf);
        check_stream("t4");

        // asynchronous reset in the middle of data bit 3
        do_reset();
        tick(1'b1, 8'h51);
        n0 = ecnt;
        tick(1'b1, 8'h9E);
        tick(1'b1, 8'h66);
        while (ecnt < n0 + 1 + 4 * DIV + 1) tick(1'b0, 8'h00);
        check("t5_tx_bit3", tx, 1'b0);
        #2;
        reset_p = 1'b1;
        #1;
        check("t5_tx_high_now", tx, 1'b1);
        check("t5_empty_now", empty, 1'b1);
        check("t5_done_now", done, 1'b1);
        check("t5_full_now", full, 1'b0);
        @(posedge clk);
        #1;
        reset_p = 1'b0;
        model_reset();
        nlow = 0;
        for (int k = 0; k < 3 * PERIOD; k++) begin
            tick(1'b0, 8'h00);
            if (tx !== 1'b1) nlow++;
        end
        check("t5_line_quiet", nlow, 0);
        check("t5_no_frames", rx_b.size(), 0);
        check("t5_done_idle", done, 1'b1);

`ifdef UART_TX_PARITY_EN
        // parity bit values
        do_reset();
        tick(1'b1, 8'h07);
        run_until_done(2 * PERIOD, ed);
        tick(1'b1, 8'h03);
        run_until_done(2 * PERIOD, ed);
        check("t6_par_07", (rx_p.size() > 0) ? rx_p[0] : 1'bx, 1'b1);
        check("t6_par_03", (rx_p.size() > 1) ? rx_p[1] : 1'bx, 1'b0);
        check_stream("t6");
`endif

        // random traffic: dense (overflowing) then sparse
        for (int r = 0; r < 2; r++) begin
            do_reset();
            for (int c = 0; c < 100; c++) begin
                w = (r == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
                tick(w, 8'($urandom));
                check("t7_empty", empty, m_fifo.size() == 0);
                check("t7_full", full, m_fifo.size() == DEPTH);
                check("t7_done", done, m_done());
                check("t7_ovf", ovf, m_ovf);
            end
            run_until_done((DEPTH + 2) * PERIOD, ed);
            check("t7_ovf_final", ovf, m_ovf);
            check_stream("t7");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
